board_io_ctrl: RTL



---
 rtl/rcpu_io_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 36 +++
 rtl/board_io_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rcpu_io_pkg.sv
// Shared definitions for the RCPU board I/O controller: mode encodings,
// CE state type and the LED page-width helper.
package rcpu_io_pkg;

    localparam logic [1:0] MODE_STEP = 2'b00;
    localparam logic [1:0] MODE_AUTO = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // State codes equal the mode codes so the FSM can follow mode by a cast.
    typedef enum logic [1:0] {
        S_STEP = MODE_STEP,
        S_AUTO = MODE_AUTO,
        S_RUN  = MODE_RUN,
        S_HOLD = MODE_HOLD
    } ce_state_t;

    function automatic int num_pg(input int dbg_w, input int led_w);
        return dbg_w / led_w;
    endfunction

    function automatic int pg_w(input int dbg_w, input int led_w);
        return (num_pg(dbg_w, led_w) <= 1) ? 1 : $clog2(num_pg(dbg_w, led_w));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Counter debouncer: the output toggles only after the input has differed
// from it for DB_CYCLES consecutive cycles; rise marks each 0->1 toggle.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (din == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                cnt  <= '0;
                dout <= ~dout;
                rise <= ~dout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O glue: button debounce, switch sync, CPU clock-enable generation
// and paged LED view of a switch-selected debug word.
module board_io_ctrl
    import rcpu_io_pkg::*;
#(
    parameter int SW_W      = 3,
    parameter int LED_W     = 8,
    parameter int DBG_W     = 32,
    parameter int DB_CYCLES = 1_000_000,
    parameter int AUTO_DIV  = 50_000_000,
    localparam int NUM_CH   = 2**SW_W,
    localparam int NUM_PG   = num_pg(DBG_W, LED_W),
    localparam int PG_W     = pg_w(DBG_W, LED_W)
) (
    input  logic                    clk_100MHz,
    input  logic                    rst,
    input  logic [1:0]              btn,
    input  logic [SW_W-1:0]         SW,
    input  logic [1:0]              mode,
    input  logic [NUM_CH*DBG_W-1:0] dbg_bus,
    output logic                    cpu_ce,
    output logic [LED_W-1:0]        LED,
    output logic [PG_W-1:0]         page,
    output logic [1:0]              btn_db,
    output logic [15:0]             step_cnt
);

    localparam int DIV_W = $clog2(AUTO_DIV);

    logic [1:0]       btn_s1, btn_s2, rise;
    logic [SW_W-1:0]  sw_s1, sw_s2, sel;
    logic [1:0]       mode_r;
    ce_state_t        state;
    logic [DIV_W-1:0] div;

    logic [NUM_CH-1:0][NUM_PG-1:0][LED_W-1:0] dbg_arr;
    assign dbg_arr = dbg_bus;

    // sel is a third switch stage so a change can be seen as sw_s2 != sel.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
            sel    <= '0;
            mode_r <= MODE_STEP;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
            sel    <= sw_s2;
            mode_r <= mode;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_db
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk_100MHz (clk_100MHz),
            .rst        (rst),
            .din        (btn_s2[i]),
            .dout       (btn_db[i]),
            .rise       (rise[i])
        );
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            state  <= S_STEP;
            div    <= '0;
            cpu_ce <= 1'b0;
        end else if (state != ce_state_t'(mode_r)) begin
            state  <= ce_state_t'(mode_r);
            div    <= '0;
            cpu_ce <= 1'b0;
        end else begin
            case (state)
                S_STEP: cpu_ce <= rise[0];
                S_AUTO: begin
                    if (div == DIV_W'(AUTO_DIV - 1)) begin
                        div    <= '0;
                        cpu_ce <= 1'b1;
                    end else begin
                        div    <= div + 1'b1;
                        cpu_ce <= 1'b0;
                    end
                end
                S_RUN:   cpu_ce <= 1'b1;
                default: cpu_ce <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            step_cnt <= '0;
        end else if (cpu_ce) begin
            step_cnt <= step_cnt + 16'd1;
        end
    end

    // A switch change takes priority over a page press in the same cycle.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            page <= '0;
        end else if (sw_s2 != sel) begin
            page <= '0;
        end else if (rise[1]) begin
            page <= (page == PG_W'(NUM_PG - 1)) ? '0 : page + 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            LED <= '0;
        end else begin
            LED <= dbg_arr[sel][page];
        end
    end

endmodule
